mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 16384, the number of 32-bit words in storage; it SHALL be a power of 2.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, the number of data-port wait cycles; it SHALL be in the range 0..15.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port instruction_address_i, input, 32 bits: fetch address.
REQ-006 SHALL have port instruction_o, output, 32 bits: fetched word.
REQ-007 SHALL have port mem_operation_enable_i, input, 1 bit: data request valid.
REQ-008 SHALL have port mem_write_enable_i, input, 4 bits: byte-lane write strobes; 0000 means a read.
REQ-009 SHALL have port mem_address_i, input, 32 bits: data address, word-aligned.
REQ-010 SHALL have port mem_data_i, input, 32 bits: write data.
REQ-011 SHALL have port mem_data_o, output, 32 bits: read data.
REQ-012 SHALL have port stall_o, output, 1 bit: pipeline hold to the core.

Function
REQ-013 SHALL index words as address[log2(MEM_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo the memory size.
REQ-014 Instruction port SHALL be a synchronous read: instruction_o is valid 1 cycle after instruction_address_i is sampled.
REQ-015 instruction_o SHALL hold its value in every cycle where stall_o=1.
REQ-016 FSM SHALL have two states, IDLE and WAIT; new data requests SHALL be accepted only in IDLE.
REQ-017 In IDLE with mem_operation_enable_i=1 and WAIT_CYCLES>0: SHALL capture address, write data and strobes; SHALL load the counter with WAIT_CYCLES-1; SHALL go to WAIT.
REQ-018 stall_o SHALL be combinational and equal (IDLE and mem_operation_enable_i) or (WAIT and counter != 0).
REQ-019 In WAIT with counter != 0, the counter SHALL decrement each cycle.
REQ-020 In WAIT with counter = 0, the captured access SHALL be performed on that edge; stall_o SHALL be 0 and the FSM SHALL return to IDLE.
REQ-021 Total stall length SHALL be exactly WAIT_CYCLES cycles per data access.
REQ-022 A write SHALL update only the lanes whose strobe bit is 1; all other bytes SHALL be preserved.
REQ-023 Read data SHALL appear on mem_data_o on the cycle after the access edge and SHALL be held until the next read completes.
REQ-024 A write SHALL leave mem_data_o unchanged.
REQ-025 On a same-word collision between fetch and data write, the write SHALL commit and the fetch SHALL return the old word (read-before-write).
REQ-026 Captured values SHALL be used in WAIT; input changes during WAIT SHALL be ignored.

Reset
REQ-027 reset=0 SHALL immediately force: FSM to IDLE, counter 0, instruction_o 0, mem_data_o 0.
REQ-028 stall_o SHALL then follow REQ-018 from IDLE, i.e. it equals mem_operation_enable_i.
REQ-029 Storage contents SHALL NOT be cleared by reset.
REQ-030 Reset asserted during WAIT SHALL abort the pending access; no write SHALL commit.

Configuration
REQ-031 Macro MEM_RESPONDER_WAIT_EN SHALL control the wait-state feature.
REQ-032 With MEM_RESPONDER_WAIT_EN defined: behaviour SHALL be as in REQ-017..REQ-021.
REQ-033 Without MEM_RESPONDER_WAIT_EN, or with WAIT_CYCLES=0: no FSM and no counter; stall_o SHALL be tied 0.
REQ-034 In that case every data access SHALL be performed on the edge where mem_operation_enable_i=1, with read data valid the next cycle.

Structure
REQ-035 Enum memResponderState_e {IDLE, WAIT} SHALL live in my_pkg.
REQ-036 The 4-bit wait-counter width constant SHALL live in my_pkg.
REQ-037 Storage SHALL be one sub-module, mem_array: dual-port, synchronous read, byte-strobed write port; the FSM SHALL remain in mem_responder.

Verification
REQ-038 Bench SHALL cover write-then-read (WAIT_CYCLES=2, macro on): write 0xDEADBEEF at 0x100 with strobes 1111 -> stall_o high 2 cycles; then a read of 0x100 -> mem_data_o=0xDEADBEEF one cycle after the access edge.
REQ-039 Bench SHALL cover byte lanes: word 0x11223344 at 0x40, then write 0xAABBCCDD with strobes 0101 -> read of 0x40 returns 0x11BB33DD.
REQ-040 Bench SHALL cover wrap (MEM_WORDS=1024): write at 0x1004 -> read at 0x0004 returns the same word.
REQ-041 Bench SHALL cover collision: fetch 0x200 and write 0x55 to 0x200 on the same edge -> instruction_o shows the old word; the next fetch returns 0x55.
REQ-042 Bench SHALL cover reset mid-WAIT: reset low during a pending write of 0x12345678 -> state IDLE, outputs 0, and a later read shows the old contents.
REQ-043 Bench SHALL cover no-wait build (macro undefined): back-to-back reads -> stall_o constantly 0, one result per cycle.

Source files
------------

// File: rtl/my_pkg.sv
// Shared types and constants for the memory responder.
// Holds the data-port FSM state encoding and the wait-counter width.
// No logic; imported by mem_responder.
package my_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } memResponderState_e;

  // Wide enough for any WAIT_CYCLES in 0..15.
  localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/mem_array.sv
// Dual-port word storage: port A is a read-only fetch port, port B is a read/write data port.
// Latency: 1 cycle on both read ports (registered outputs); writes land on the enable edge.
// Backpressure: none; fetch_en low holds fetch_dat, data reads hold data_rdat until the next read.
// Ports: clk, reset (async active-low, clears the output registers only),
//   fetch_en/fetch_idx -> fetch_dat, data_en/data_we/data_idx/data_wdat -> data_rdat.
module mem_array #(
  parameter int WORDS = 16384,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fetch_en,
  input  logic [AW-1:0] fetch_idx,
  output logic [31:0]   fetch_dat,
  input  logic          data_en,
  input  logic [3:0]    data_we,
  input  logic [AW-1:0] data_idx,
  input  logic [31:0]   data_wdat,
  output logic [31:0]   data_rdat
);

  logic [31:0] mem [WORDS];

  // Storage is deliberately not reset so contents survive a core reset.
  always_ff @(posedge clk) begin
    if (data_en) begin
      for (int b = 0; b < 4; b++) begin
        if (data_we[b]) begin
          mem[data_idx][8*b +: 8] <= data_wdat[8*b +: 8];
        end
      end
    end
  end

  // Reads sample the array before this edge's write, so a same-word
  // fetch/write collision returns the old word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_dat <= '0;
      data_rdat <= '0;
    end else begin
      if (fetch_en) begin
        fetch_dat <= mem[fetch_idx];
      end
      if (data_en && (data_we == 4'b0000)) begin
        data_rdat <= mem[data_idx];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Instruction + data memory responder for a simple core, with optional data-port wait states.
// Latency: fetch 1 cycle; data access WAIT_CYCLES stall cycles, then result 1 cycle after the access edge.
// Backpressure: stall_o holds the core; instruction_o is frozen while stalled.
// Ports: clk, reset (async active-low), instruction_address_i -> instruction_o,
//   mem_operation_enable_i/mem_write_enable_i/mem_address_i/mem_data_i -> mem_data_o, stall_o.
// Build option: define MEM_RESPONDER_WAIT_EN to enable the wait-state FSM; otherwise
//   (or with WAIT_CYCLES=0) every data access completes on its request edge and stall_o is 0.
module mem_responder
  import my_pkg::*;
#(
  parameter int MEM_WORDS   = 16384,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction_address_i,
  output logic [31:0] instruction_o,
  input  logic        mem_operation_enable_i,
  input  logic [3:0]  mem_write_enable_i,
  input  logic [31:0] mem_address_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        stall_o
);

  localparam int AW = $clog2(MEM_WORDS);

`ifdef MEM_RESPONDER_WAIT_EN
  localparam bit WAIT_BUILD = 1'b1;
`else
  localparam bit WAIT_BUILD = 1'b0;
`endif
  localparam bit USE_WAIT = WAIT_BUILD && (WAIT_CYCLES > 0);

  logic [AW-1:0] fetch_idx;
  logic [AW-1:0] req_idx;
  logic          arr_en;
  logic [3:0]    arr_we;
  logic [AW-1:0] arr_idx;
  logic [31:0]   arr_wdat;

  // Byte offset and bits above the array size are dropped: addresses wrap.
  assign fetch_idx = instruction_address_i[AW+1:2];
  assign req_idx   = mem_address_i[AW+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{instruction_address_i[31:AW+2], instruction_address_i[1:0],
                              mem_address_i[31:AW+2], mem_address_i[1:0]};

  generate
    if (USE_WAIT) begin : g_wait
      memResponderState_e    state_q, state_d;
      logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
      logic [AW-1:0]         idx_q, idx_d;
      logic [3:0]            we_q, we_d;
      logic [31:0]           wdat_q, wdat_d;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          idx_q   <= '0;
          we_q    <= '0;
          wdat_q  <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          idx_q   <= idx_d;
          we_q    <= we_d;
          wdat_q  <= wdat_d;
        end
      end

      // The request cycle itself is the first stall cycle, so the counter
      // starts at WAIT_CYCLES-1 and the access fires when it reaches zero.
      always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        we_d     = we_q;
        wdat_d   = wdat_q;
        stall_o  = 1'b0;
        arr_en   = 1'b0;
        arr_we   = we_q;
        arr_idx  = idx_q;
        arr_wdat = wdat_q;
        case (state_q)
          IDLE: begin
            if (mem_operation_enable_i) begin
              stall_o = 1'b1;
              idx_d   = req_idx;
              we_d    = mem_write_enable_i;
              wdat_d  = mem_data_i;
              cnt_d   = WAIT_CNT_W'(WAIT_CYCLES - 1);
              state_d = WAIT;
            end
          end
          WAIT: begin
            if (cnt_q != '0) begin
              stall_o = 1'b1;
              cnt_d   = cnt_q - WAIT_CNT_W'(1);
            end else begin
              arr_en  = 1'b1;
              state_d = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end else begin : g_nowait
      assign stall_o  = 1'b0;
      assign arr_en   = mem_operation_enable_i;
      assign arr_we   = mem_write_enable_i;
      assign arr_idx  = req_idx;
      assign arr_wdat = mem_data_i;
    end
  endgenerate

  mem_array #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_mem_array (
    .clk       (clk),
    .reset     (reset),
    .fetch_en  (!stall_o),
    .fetch_idx (fetch_idx),
    .fetch_dat (instruction_o),
    .data_en   (arr_en),
    .data_we   (arr_we),
    .data_idx  (arr_idx),
    .data_wdat (arr_wdat),
    .data_rdat (mem_data_o)
  );

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int MEM_WORDS   = 1024;
  localparam int WAIT_CYCLES = 2;
`ifdef MEM_RESPONDER_WAIT_EN
  localparam int          EXP_STALL = WAIT_CYCLES;
  localparam logic [31:0] EXP_300   = 32'h0BADC0DE;
`else
  localparam int          EXP_STALL = 0;
  localparam logic [31:0] EXP_300   = 32'h12345678;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction_address_i;
  logic [31:0] instruction_o;
  logic        mem_operation_enable_i;
  logic [3:0]  mem_write_enable_i;
  logic [31:0] mem_address_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        stall_o;

  always #5 clk = ~clk;

  mem_responder #(
    .MEM_WORDS   (MEM_WORDS),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .instruction_address_i  (instruction_address_i),
    .instruction_o          (instruction_o),
    .mem_operation_enable_i (mem_operation_enable_i),
    .mem_write_enable_i     (mem_write_enable_i),
    .mem_address_i          (mem_address_i),
    .mem_data_i             (mem_data_i),
    .mem_data_o             (mem_data_o),
    .stall_o                (stall_o)
  );

  typedef struct {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [31:0] exp_dout;
  } vec_t;

  int          total  = 0;
  int          passed = 0;
  logic [31:0] sb[$];
  vec_t        vecs[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Issue one data access and follow it to completion. Called at posedge+1.
  task automatic access(input string nm, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wdat, input logic [31:0] exp_dout);
    int          n;
    bit          held;
    logic [31:0] ins0;
    logic [31:0] exp;
    sb.push_back(exp_dout);
    mem_operation_enable_i = 1'b1;
    mem_write_enable_i     = we;
    mem_address_i          = addr;
    mem_data_i             = wdat;
    #1;
    n    = 0;
    held = 1'b1;
    ins0 = instruction_o;
    while (stall_o && n < 40) begin
      n++;
      @(posedge clk); #1;
      // Inputs are scrambled while waiting; the captured request must win.
      mem_operation_enable_i = 1'b0;
      mem_address_i          = ~addr;
      mem_data_i             = ~wdat;
      mem_write_enable_i     = 4'hF;
      #1;
      if (instruction_o !== ins0) held = 1'b0;
    end
    @(posedge clk); #1;
    mem_operation_enable_i = 1'b0;
    #1;
    check({nm, " stall_len"}, n, EXP_STALL);
    check({nm, " instr_hold"}, {31'd0, held}, 32'd1);
    exp = sb.pop_front();
    check({nm, " dout"}, mem_data_o, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra[5];
    logic [31:0] re[5];

    vecs[0]  = '{4'hF, 32'h0000_0100, 32'hDEADBEEF, 32'h0000_0000};
    vecs[1]  = '{4'h0, 32'h0000_0100, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{4'hF, 32'h0000_0040, 32'h11223344, 32'hDEADBEEF};
    vecs[3]  = '{4'h5, 32'h0000_0040, 32'hAABBCCDD, 32'hDEADBEEF};
    vecs[4]  = '{4'h0, 32'h0000_0040, 32'h0,        32'h11BB33DD};
    vecs[5]  = '{4'hF, 32'h0000_1004, 32'hCAFEF00D, 32'h11BB33DD};
    vecs[6]  = '{4'h0, 32'h0000_0004, 32'h0,        32'hCAFEF00D};
    vecs[7]  = '{4'hF, 32'h0000_0008, 32'h0000FFFF, 32'hCAFEF00D};
    vecs[8]  = '{4'hA, 32'h0000_0008, 32'h12345678, 32'hCAFEF00D};
    vecs[9]  = '{4'h0, 32'h0000_0008, 32'h0,        32'h120056FF};
    vecs[10] = '{4'hF, 32'h0000_0200, 32'hA5A5A5A5, 32'h120056FF};
    vecs[11] = '{4'hF, 32'h0000_0300, 32'h0BADC0DE, 32'h120056FF};

    ra = '{32'h100, 32'h40, 32'h4, 32'h8, 32'h200};
    re = '{32'hDEADBEEF, 32'h11BB33DD, 32'hCAFEF00D, 32'h120056FF, 32'h00000055};

    // Reset state
    reset                  = 1'b0;
    instruction_address_i  = 32'h0;
    mem_operation_enable_i = 1'b1;
    mem_write_enable_i     = 4'h0;
    mem_address_i          = 32'h0;
    mem_data_i             = 32'h0;
    #1;
    check("rst stall_en1", {31'd0, stall_o}, (EXP_STALL > 0) ? 32'd1 : 32'd0);
    check("rst instr", instruction_o, 32'h0);
    check("rst dout", mem_data_o, 32'h0);
    mem_operation_enable_i = 1'b0;
    #1;
    check("rst stall_en0", {31'd0, stall_o}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Table-driven accesses
    for (int i = 0; i < 12; i++) begin
      access($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdat, vecs[i].exp_dout);
    end

    // Fetch/write collision on word 0x200: read-before-write
    instruction_address_i = 32'h200;
    access("coll_wr", 4'hF, 32'h200, 32'h00000055, 32'h120056FF);
    check("coll old_word", instruction_o, 32'hA5A5A5A5);
    @(posedge clk); #1;
    check("coll new_word", instruction_o, 32'h00000055);

    // Reset while a write of 0x12345678 to 0x300 is pending
    mem_operation_enable_i = 1'b1;
    mem_write_enable_i     = 4'hF;
    mem_address_i          = 32'h300;
    mem_data_i             = 32'h12345678;
    @(posedge clk); #1;
    mem_operation_enable_i = 1'b0;
    reset                  = 1'b0;
    #1;
    check("midrst instr", instruction_o, 32'h0);
    check("midrst dout", mem_data_o, 32'h0);
    check("midrst stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    access("midrst rd300", 4'h0, 32'h300, 32'h0, EXP_300);

    // Streaming reads
`ifdef MEM_RESPONDER_WAIT_EN
    for (int i = 0; i < 5; i++) begin
      access($sformatf("stream%0d", i), 4'h0, ra[i], 32'h0, re[i]);
    end
`else
    mem_operation_enable_i = 1'b1;
    mem_write_enable_i     = 4'h0;
    mem_address_i          = ra[0];
    sb.push_back(re[0]);
    #1;
    check("stream stall0", {31'd0, stall_o}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      logic [31:0] e;
      @(posedge clk); #1;
      e = sb.pop_front();
      check($sformatf("stream%0d dout", i), mem_data_o, e);
      check($sformatf("stream%0d stall", i), {31'd0, stall_o}, 32'd0);
      if (i < 4) begin
        mem_address_i = ra[i+1];
        sb.push_back(re[i+1]);
      end else begin
        mem_operation_enable_i = 1'b0;
      end
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
